// File: rtl/ball_motion.sv
// Ball position/direction engine for a paddle game: serve, move on tick,
// reflect off walls and paddle, and report a miss at the goal line.
module ball_motion #(
   parameter int W      = 11,
   parameter int STEP_W = 4,
   parameter int H_MIN  = 0,
   parameter int H_MAX  = 639,
   parameter int V_MIN  = 0,
   parameter int V_MAX  = 479,
   parameter int H_INIT = 200,
   parameter int V_INIT = 300
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              tick_i,
   input  logic              pause_i,
   input  logic              serve_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              hit_i,
   output logic [W-1:0]      h_pos_o,
   output logic [W-1:0]      v_pos_o,
   output logic              dh_o,
   output logic              dv_o,
   output logic              running_o,
   output logic              bounce_o,
   output logic              miss_o
);

   localparam int XW = W + 1;
   localparam logic [XW-1:0] HMIN_X = XW'(H_MIN);
   localparam logic [XW-1:0] HMAX_X = XW'(H_MAX);
   localparam logic [XW-1:0] VMIN_X = XW'(V_MIN);
   localparam logic [XW-1:0] VMAX_X = XW'(V_MAX);

   typedef enum logic [1:0] {S_SERVE, S_RUN, S_OUT} state_t;

   state_t              state_q;
   logic [W-1:0]        h_q, v_q, h_d, v_d;
   logic                dh_q, dv_q, dh_d, dv_d;
   logic [STEP_W-1:0]   stp_q, serve_stp;
   logic                running_q, bounce_q, miss_q;
   logic                h_bnc, v_bnc, v_miss;
   logic [XW-1:0]       h_x, v_x, stp_x;

   assign serve_stp = (step_i == '0) ? STEP_W'(1) : step_i;

   // Move arithmetic at W+1 bits so neither add nor subtract can wrap.
   always_comb begin
      h_x   = XW'(h_q);
      v_x   = XW'(v_q);
      stp_x = XW'(stp_q);
      h_d    = h_q;
      v_d    = v_q;
      dh_d   = dh_q;
      dv_d   = dv_q;
      h_bnc  = 1'b0;
      v_bnc  = 1'b0;
      v_miss = 1'b0;
      if (dh_q) begin
         if (h_x + stp_x >= HMAX_X) begin
            h_d = W'(H_MAX); dh_d = 1'b0; h_bnc = 1'b1;
         end else begin
            h_d = W'(h_x + stp_x);
         end
      end else begin
         if (h_x <= HMIN_X + stp_x) begin
            h_d = W'(H_MIN); dh_d = 1'b1; h_bnc = 1'b1;
         end else begin
            h_d = W'(h_x - stp_x);
         end
      end
      if (!dv_q) begin
         if (v_x <= VMIN_X + stp_x) begin
            v_d = W'(V_MIN); dv_d = 1'b1; v_bnc = 1'b1;
         end else begin
            v_d = W'(v_x - stp_x);
         end
      end else if (hit_i) begin
         v_d   = (v_x <= VMIN_X + stp_x) ? W'(V_MIN) : W'(v_x - stp_x);
         dv_d  = 1'b0;
         v_bnc = 1'b1;
      end else if (v_x + stp_x >= VMAX_X) begin
         v_d    = W'(V_MAX);
         v_miss = 1'b1;
      end else begin
         v_d = W'(v_x + stp_x);
      end
      // A miss keeps both directions as they were; only the position clamps.
      if (v_miss) begin
         dh_d  = dh_q;
         h_bnc = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_SERVE;
         h_q       <= W'(H_INIT);
         v_q       <= W'(V_INIT);
         dh_q      <= 1'b1;
         dv_q      <= 1'b0;
         stp_q     <= STEP_W'(1);
         running_q <= 1'b0;
         bounce_q  <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         bounce_q <= 1'b0;
         miss_q   <= 1'b0;
         if (!pause_i) begin
            case (state_q)
               S_SERVE, S_OUT: begin
                  if (serve_i) begin
                     state_q   <= S_RUN;
                     h_q       <= W'(H_INIT);
                     v_q       <= W'(V_INIT);
                     dh_q      <= 1'b1;
                     dv_q      <= 1'b0;
                     stp_q     <= serve_stp;
                     running_q <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (tick_i) begin
                     h_q      <= h_d;
                     v_q      <= v_d;
                     dh_q     <= dh_d;
                     dv_q     <= dv_d;
                     bounce_q <= h_bnc | v_bnc;
                     miss_q   <= v_miss;
                     if (v_miss) begin
                        state_q   <= S_OUT;
                        running_q <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_q   <= S_SERVE;
                  running_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign h_pos_o   = h_q;
   assign v_pos_o   = v_q;
   assign dh_o      = dh_q;
   assign dv_o      = dv_q;
   assign running_o = running_q;
   assign bounce_o  = bounce_q;
   assign miss_o    = miss_q;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus random
// stimulus, all compared against an integer reference model.
module tb_ball_motion;

   localparam int W = 11, STEP_W = 4;
   localparam int HMIN = 0, HMAX = 639, VMIN = 0, VMAX = 479;
   localparam int HINIT = 200, VINIT = 300;

   logic clk = 1'b0;
   logic rst, tick, pause, serve, hit;
   logic [STEP_W-1:0] step;
   logic [W-1:0] h_pos, v_pos;
   logic dh, dv, running, bounce, miss;

   int errors = 0, checks = 0;

   // Reference model: 0=serve, 1=run, 2=out
   int m_st, m_h, m_v, m_dh, m_dv, m_s, m_b, m_m;
   int snap_h, snap_v, snap_dh, snap_dv;

   always #5 clk = ~clk;

   ball_motion #(.W(W), .STEP_W(STEP_W)) dut (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .pause_i(pause),
      .serve_i(serve), .step_i(step), .hit_i(hit),
      .h_pos_o(h_pos), .v_pos_o(v_pos), .dh_o(dh), .dv_o(dv),
      .running_o(running), .bounce_o(bounce), .miss_o(miss)
   );

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int nh, nv, ndh, ndv, hb, vb, ms;
      if (rst) begin
         m_st = 0; m_h = HINIT; m_v = VINIT; m_dh = 1; m_dv = 0;
         m_s = 1; m_b = 0; m_m = 0;
      end else begin
         m_b = 0; m_m = 0;
         if (pause) begin
         end else if (m_st != 1) begin
            if (serve) begin
               m_st = 1; m_h = HINIT; m_v = VINIT; m_dh = 1; m_dv = 0;
               m_s = (step == 0) ? 1 : int'(step);
            end
         end else if (tick) begin
            hb = 0; vb = 0; ms = 0; ndh = m_dh; ndv = m_dv;
            nh = m_dh ? m_h + m_s : m_h - m_s;
            if (nh >= HMAX) begin nh = HMAX; ndh = 0; hb = 1; end
            else if (nh <= HMIN) begin nh = HMIN; ndh = 1; hb = 1; end
            if (m_dv == 0) begin
               nv = m_v - m_s;
               if (nv <= VMIN) begin nv = VMIN; ndv = 1; vb = 1; end
            end else if (hit) begin
               nv = (m_v - m_s < VMIN) ? VMIN : m_v - m_s;
               ndv = 0; vb = 1;
            end else begin
               nv = m_v + m_s;
               if (nv >= VMAX) begin nv = VMAX; ms = 1; end
            end
            if (ms) begin ndh = m_dh; hb = 0; m_st = 2; end
            m_h = nh; m_v = nv; m_dh = ndh; m_dv = ndv;
            m_b = hb | vb; m_m = ms;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("h_pos", int'(h_pos), m_h);
      chk("v_pos", int'(v_pos), m_v);
      chk("dh", int'(dh), m_dh);
      chk("dv", int'(dv), m_dv);
      chk("running", int'(running), int'(m_st == 1));
      chk("bounce", int'(bounce), m_b);
      chk("miss", int'(miss), m_m);
   endtask

   task automatic drive(input logic r, input logic p, input logic s,
                        input logic t, input logic h, input int st);
      rst = r; pause = p; serve = s; tick = t; hit = h; step = STEP_W'(st);
   endtask

   task automatic reset_serve(input int st);
      drive(1, 0, 0, 0, 0, 0); cycle();
      drive(0, 0, 1, 0, 0, st); cycle();
   endtask

   task automatic climb_to_476();
      reset_serve(4);
      for (int i = 0; i < 400 && !(m_v == 476 && m_dv == 1); i++) begin
         drive(0, 0, 0, 1, 0, 0); cycle();
      end
      chk("reach_v476", int'(m_v == 476 && m_dv == 1), 1);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      m_st = 0; m_h = 0; m_v = 0; m_dh = 0; m_dv = 0; m_s = 1; m_b = 0; m_m = 0;
      cycle();
      chk("rst_h", int'(h_pos), 200);
      chk("rst_v", int'(v_pos), 300);
      chk("rst_running", int'(running), 0);

      // Serve step 2, three ticks
      drive(0, 0, 1, 0, 0, 2); cycle();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 1, 0, 0); cycle(); end
      chk("d1_h", int'(h_pos), 206);
      chk("d1_v", int'(v_pos), 294);
      chk("d1_running", int'(running), 1);

      // Right wall with step 5
      reset_serve(5);
      for (int i = 0; i < 200 && m_h != HMAX; i++) begin drive(0, 0, 0, 1, 0, 0); cycle(); end
      chk("d2_h", int'(h_pos), 639);
      chk("d2_dh", int'(dh), 0);
      chk("d2_bounce", int'(bounce), 1);
      drive(0, 0, 0, 0, 0, 0); cycle();
      chk("d2_bounce_end", int'(bounce), 0);
      drive(0, 0, 0, 1, 0, 0); cycle();
      chk("d2_h_next", int'(h_pos), 634);

      // Paddle hit at v=476
      climb_to_476();
      drive(0, 0, 0, 1, 1, 0); cycle();
      chk("d3_v_hit", int'(v_pos), 472);
      chk("d3_dv_hit", int'(dv), 0);
      chk("d3_bounce_hit", int'(bounce), 1);
      chk("d3_miss_hit", int'(miss), 0);

      // Miss at v=476
      climb_to_476();
      drive(0, 0, 0, 1, 0, 0); cycle();
      chk("d4_v_miss", int'(v_pos), 479);
      chk("d4_miss", int'(miss), 1);
      chk("d4_running", int'(running), 0);
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 1, 1, 0); cycle(); end
      chk("d4_v_frozen", int'(v_pos), 479);
      drive(0, 0, 1, 1, 0, 3); cycle();
      chk("d4_reserve_h", int'(h_pos), 200);
      chk("d4_reserve_v", int'(v_pos), 300);
      chk("d4_reserve_run", int'(running), 1);

      // Pause freeze
      for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 1, 0, 0); cycle(); end
      snap_h = m_h; snap_v = m_v; snap_dh = m_dh; snap_dv = m_dv;
      for (int i = 0; i < 10; i++) begin drive(0, 1, (i == 4), 1, 1, 7); cycle(); end
      chk("d5_h", int'(h_pos), snap_h);
      chk("d5_v", int'(v_pos), snap_v);
      chk("d5_dh", int'(dh), snap_dh);
      chk("d5_dv", int'(dv), snap_dv);
      drive(0, 0, 0, 1, 0, 0); cycle();
      chk("d5_resume_h", int'(h_pos), snap_h + 3);

      // Step 0 maps to 1; reset mid-move
      reset_serve(0);
      drive(0, 0, 0, 1, 0, 0); cycle();
      chk("d6_h", int'(h_pos), 201);
      chk("d6_v", int'(v_pos), 299);
      drive(1, 1, 1, 1, 1, 9); cycle();
      chk("d6_rst_h", int'(h_pos), 200);
      chk("d6_rst_v", int'(v_pos), 300);
      chk("d6_rst_running", int'(running), 0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameter W, default 11, width of h_pos/v_pos.
REQ-002 Parameter STEP_W, default 4, width of step input.
REQ-003 Parameters H_MIN/H_MAX, default 0/639, horizontal bounds in pixels.
REQ-004 Parameters V_MIN/V_MAX, default 0/479, vertical bounds; V_MAX is the goal line.
REQ-005 Parameters H_INIT/V_INIT, default 200/300, serve position.
REQ-006 clk  in  1  system clock; single clock domain, all state on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 tick  in  1  one-cycle move strobe, typically once per frame.
REQ-009 pause  in  1  level; 1 freezes all state.
REQ-010 serve  in  1  one-cycle strobe; launches ball from SERVE or OUT.
REQ-011 step  in  STEP_W  pixels per move; sampled on accepted serve.
REQ-012 hit  in  1  paddle-contact level, sampled on move ticks.
REQ-013 h_pos, v_pos  out  W  registered ball position.
REQ-014 dh, dv  out  1  registered direction; dh=1 right (+h), dv=1 down (+v).
REQ-015 running  out  1  high only in RUN.
REQ-016 bounce  out  1  one-cycle pulse on any wall or paddle reversal.
REQ-017 miss  out  1  one-cycle pulse on RUN->OUT.

Function
REQ-018 FSM shall have states SERVE, RUN, OUT.
REQ-019 When pause=1, no state, position, direction or latched step shall change; tick and serve shall be ignored; bounce and miss shall be 0.
REQ-020 SERVE: position held at H_INIT/V_INIT; on serve go to RUN, latch step (0 replaced by 1), set dh=1, dv=0.
REQ-021 RUN: a move occurs only on a cycle with tick=1; position updates the cycle after tick (1-cycle latency).
REQ-022 Horizontal move: dh=1 -> h+stp; dh=0 -> h-stp; computed at W+1 bits, no wraparound.
REQ-023 If dh=1 and h+stp >= H_MAX, h shall clamp to H_MAX, dh shall become 0, bounce=1.
REQ-024 If dh=0 and h <= H_MIN+stp, h shall clamp to H_MIN, dh shall become 1, bounce=1.
REQ-025 If dv=0 and v <= V_MIN+stp, v shall clamp to V_MIN, dv shall become 1, bounce=1.
REQ-026 If dv=1 and hit=1 on a move tick, v shall become max(v-stp, V_MIN), dv shall become 0, bounce=1, no miss.
REQ-027 If dv=1, hit=0, v+stp >= V_MAX: v shall clamp to V_MAX, state -> OUT, miss=1 for one cycle, dh/dv held.
REQ-028 Horizontal and vertical rules shall be evaluated independently in the same move; a corner produces both reversals and a single bounce pulse.
REQ-029 hit shall be ignored when dv=0 or outside RUN.
REQ-030 OUT: position and direction frozen; on serve, return position to H_INIT/V_INIT, latch new step, dh=1, dv=0, enter RUN.
REQ-031 serve during RUN shall be ignored; serve and tick in the same SERVE/OUT cycle shall serve only, no move that cycle.

Reset
REQ-032 rst=1 at a clock edge shall force: state SERVE, h_pos=H_INIT, v_pos=V_INIT, dh=1, dv=0, latched step=1, running=0, bounce=0, miss=0.
REQ-033 rst shall override pause, serve, tick and hit, including mid-move.

Verification
REQ-034 rst, then serve with step=2, tick x3 -> h_pos 200->206, v_pos 300->294, running=1, no bounce.
REQ-035 serve step=5, run to right wall -> h_pos clamps 639, dh=0, bounce single cycle, next tick h=634.
REQ-036 ball dv=1 at v=476, step=4, tick with hit=0 -> v_pos=479, miss pulse, state OUT; further ticks no change; serve -> 200/300, RUN.
REQ-037 same setup with hit=1 -> v_pos=472, dv=0, bounce=1, miss=0.
REQ-038 pause=1 across 10 ticks and a serve -> all outputs constant; pause release resumes on next tick.
REQ-039 serve with step=0 -> moves by 1 per tick; rst asserted mid-RUN with tick -> 200/300, SERVE next cycle.
